hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core. Consumes register indices and control bits from the decode, execute and memory stages.
- Generates per-stage stall/flush (bubble) enables for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves load-use hazards, taken-branch/jump flushes and multi-cycle data-memory waits.
- Keeps a timeout watchdog and hazard performance counters.

Parameters:
- MEM_TIMEOUT, 256: max consecutive MEM_WAIT cycles before the sticky error.
- CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1  in  5  rs1 index of instruction in ID
- id_rs2  in  5  rs2 index of instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_MemRead  in  1  instruction in EX is a load
- ex_rd  in  5  destination of instruction in EX
- ex_br_taken  in  1  EX resolved taken branch/JAL/JALR (pc redirect)
- mem_access  in  1  MEM-stage instruction issues a data-memory read or write
- mem_ready  in  1  data memory completes the access this cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_stall  out  1  hold ID/EX
- id_ex_flush  out  1  load bubble into ID/EX (all control bits 0)
- ex_mem_stall  out  1  hold EX/MEM
- mem_wb_flush  out  1  load bubble into MEM/WB
- mem_timeout_err  out  1  sticky watchdog error
- stall_cnt  out  CNT_W  cycles with pc_stall=1
- flush_cnt  out  CNT_W  cycles with if_id_flush=1
- loaduse_cnt  out  CNT_W  load-use stall events

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN, wait counter=0, mem_timeout_err=0, all counters=0.
  - All stall/flush outputs are combinational, so they are 0 while in reset.
- States: RUN, MEM_WAIT, ERR.
  - RUN -> MEM_WAIT when mem_access && !mem_ready.
  - MEM_WAIT -> RUN on the cycle mem_ready=1.
  - MEM_WAIT -> ERR when the wait counter reaches MEM_TIMEOUT-1 without mem_ready.
  - ERR is terminal until reset: mem_timeout_err=1 and the whole pipeline stays frozen.
- Wait counter:
  - Clears on entering MEM_WAIT and increments each MEM_WAIT cycle.
  - Saturates; no wrap.
- mem_busy = mem_access && !mem_ready, any state.
- Frozen = mem_busy || state==ERR. While frozen:
  - pc_stall=if_id_stall=id_ex_stall=ex_mem_stall=1 and mem_wb_flush=1.
  - No other flush.
  - Load-use and branch outputs are suppressed; the held instructions re-evaluate them after release.
- mem_ready and mem_access high in the same cycle: no stall, zero-cycle access.
- Load-use, when not frozen: ex_MemRead && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
  - Response: pc_stall=1, if_id_stall=1, id_ex_flush=1. Exactly one cycle per event, since the load advances.
- Branch, when not frozen: ex_br_taken=1 -> if_id_flush=1, id_ex_flush=1, pc_stall=0.
  - Branch overrides load-use in the same cycle: the ID instruction is discarded, so no stall and loaduse_cnt is not incremented.
- Branch pending under a memory freeze: the flush is issued on the first non-frozen cycle, because EX still holds the branch. No extra state is needed.
- x0 never causes a hazard.
- Counters:
  - Saturate at all-ones.
  - Update at posedge from the current-cycle outputs.
  - Not incremented in ERR.
- No output depends on the wait counter except through the state.

Decomposition:
- Package hazard_definitions holds:
  - typedef enum logic [1:0] hz_state_t {HZ_RUN, HZ_MEM_WAIT, HZ_ERR};
  - default MEM_TIMEOUT localparam.
  - packed struct hz_ctrl_t bundling the seven stall/flush bits.
- One sub-module, hazard_perf_cnt: saturating CNT_W counter with increment enable, instantiated three times.

Test Plan:
- Load-use: ex_MemRead=1, ex_rd=5, id_rs2=5, id_use_rs2=1, mem idle -> one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1; loaduse_cnt 0->1; ex_rd=0 with id_rs1=0 -> no stall.
- Branch vs load-use: ex_br_taken=1 with a load-use match the same cycle -> if_id_flush=1, id_ex_flush=1, pc_stall=0; flush_cnt=1, loaduse_cnt=0.
- Memory wait: mem_access=1, mem_ready=0 for 3 cycles then 1 -> all stalls and mem_wb_flush high for 3 cycles, state returns to RUN, stall_cnt=3; mem_access=mem_ready=1 together -> 0 stall cycles.
- Branch under freeze: ex_br_taken=1 during a 2-cycle memory wait -> no flush during the wait; flush asserted on the release cycle.
- Timeout: MEM_TIMEOUT=8, mem_ready held 0 -> mem_timeout_err=1 after 8 wait cycles; stays 1 and pipeline stays frozen after mem_ready=1; rst_n pulse mid-state -> immediate RUN, all outputs and counters 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, the
// stall/flush control bundle and the default memory watchdog limit.
package hazard_definitions;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_MEM_WAIT,
        HZ_ERR
    } hz_state_t;

    localparam int unsigned HZ_MEM_TIMEOUT_DEF = 256;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic mem_wb_flush;
    } hz_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_perf_cnt.sv
// Saturating event counter: increments on i_inc and holds at all-ones.
module hazard_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes,
// data-memory wait freezes with a timeout watchdog, and hazard counters.
module hazard_ctrl
    import hazard_definitions::*;
#(
    parameter int unsigned MEM_TIMEOUT = HZ_MEM_TIMEOUT_DEF,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rd,
    input  logic             ex_br_taken,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_flush,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] loaduse_cnt
);

    localparam int unsigned WC_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_t       r_state;
    hz_state_t       w_state_nxt;
    logic [WC_W-1:0] r_wait_cnt;
    logic [WC_W-1:0] w_wait_cnt_nxt;
    logic            w_mem_busy;
    logic            w_frozen;
    logic            w_load_use;
    logic            w_cnt_run;
    hz_ctrl_t        w_ctrl;

    assign w_mem_busy = mem_access && !mem_ready;
    assign w_frozen   = w_mem_busy || (r_state == HZ_ERR);
    assign w_load_use = ex_MemRead && (ex_rd != 5'd0) &&
                        ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                         (id_use_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= HZ_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Leaving MEM_WAIT on any non-busy cycle keeps the watchdog tied to
    // consecutive stalled cycles only.
    always_comb begin : next_state
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        unique case (r_state)
            HZ_RUN: begin
                if (w_mem_busy) begin
                    w_state_nxt    = HZ_MEM_WAIT;
                    w_wait_cnt_nxt = '0;
                end
            end
            HZ_MEM_WAIT: begin
                if (!w_mem_busy) begin
                    w_state_nxt = HZ_RUN;
                end else if (r_wait_cnt == WC_W'(MEM_TIMEOUT - 1)) begin
                    w_state_nxt = HZ_ERR;
                end else if (r_wait_cnt != '1) begin
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                end
            end
            HZ_ERR: begin
            end
            default: begin
                w_state_nxt = HZ_RUN;
            end
        endcase
    end

    // Branch beats load-use because the ID instruction is discarded anyway.
    always_comb begin : ctrl_out
        w_ctrl = '0;
        if (w_frozen) begin
            w_ctrl.pc_stall     = 1'b1;
            w_ctrl.if_id_stall  = 1'b1;
            w_ctrl.id_ex_stall  = 1'b1;
            w_ctrl.ex_mem_stall = 1'b1;
            w_ctrl.mem_wb_flush = 1'b1;
        end else if (ex_br_taken) begin
            w_ctrl.if_id_flush = 1'b1;
            w_ctrl.id_ex_flush = 1'b1;
        end else if (w_load_use) begin
            w_ctrl.pc_stall    = 1'b1;
            w_ctrl.if_id_stall = 1'b1;
            w_ctrl.id_ex_flush = 1'b1;
        end
        if (!rst_n) begin
            w_ctrl = '0;
        end
    end

    assign pc_stall        = w_ctrl.pc_stall;
    assign if_id_stall     = w_ctrl.if_id_stall;
    assign if_id_flush     = w_ctrl.if_id_flush;
    assign id_ex_stall     = w_ctrl.id_ex_stall;
    assign id_ex_flush     = w_ctrl.id_ex_flush;
    assign ex_mem_stall    = w_ctrl.ex_mem_stall;
    assign mem_wb_flush    = w_ctrl.mem_wb_flush;
    assign mem_timeout_err = (r_state == HZ_ERR);

    assign w_cnt_run = (r_state != HZ_ERR);

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_cnt_run && w_ctrl.pc_stall),
        .o_cnt (stall_cnt)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_cnt_run && w_ctrl.if_id_flush),
        .o_cnt (flush_cnt)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_loaduse_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_cnt_run && !w_frozen && !ex_br_taken && w_load_use),
        .o_cnt (loaduse_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic compared against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int unsigned TO    = 8;
    localparam int unsigned CW    = 5;
    localparam int          MAXC  = (1 << CW) - 1;

    localparam logic [6:0] C_FROZEN = 7'b1101011;
    localparam logic [6:0] C_BRANCH = 7'b0010100;
    localparam logic [6:0] C_LDUSE  = 7'b1100100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic          ex_MemRead = 1'b0, ex_br_taken = 1'b0;
    logic          mem_access = 1'b0, mem_ready = 1'b0;
    logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall;
    logic          id_ex_flush, ex_mem_stall, mem_wb_flush, mem_timeout_err;
    logic [CW-1:0] stall_cnt, flush_cnt, loaduse_cnt;
    logic [6:0]    obs;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    bit m_err;
    int m_streak, m_stall, m_flush, m_loaduse;

    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_MemRead      (ex_MemRead),
        .ex_rd           (ex_rd),
        .ex_br_taken     (ex_br_taken),
        .mem_access      (mem_access),
        .mem_ready       (mem_ready),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_stall     (id_ex_stall),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_stall    (ex_mem_stall),
        .mem_wb_flush    (mem_wb_flush),
        .mem_timeout_err (mem_timeout_err),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .loaduse_cnt     (loaduse_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                  id_ex_flush, ex_mem_stall, mem_wb_flush};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [6:0] exp_ctrl();
        bit busy, hz;
        busy = mem_access && !mem_ready;
        hz   = ex_MemRead && (ex_rd != 0) &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (!rst_n)         return 7'b0;
        if (busy || m_err)  return C_FROZEN;
        if (ex_br_taken)    return C_BRANCH;
        if (hz)             return C_LDUSE;
        return 7'b0;
    endfunction

    function automatic logic [3*CW:0] exp_stat();
        return {m_err, CW'(m_stall), CW'(m_flush), CW'(m_loaduse)};
    endfunction

    function automatic int sat(input int v);
        return (v < MAXC) ? v + 1 : MAXC;
    endfunction

    // Advance model with the inputs held across the edge, then the DUT.
    task automatic tick();
        logic [6:0] e;
        e = exp_ctrl();
        if (!m_err) begin
            if (e[6])         m_stall   = sat(m_stall);
            if (e[4])         m_flush   = sat(m_flush);
            if (e == C_LDUSE) m_loaduse = sat(m_loaduse);
        end
        if (mem_access && !mem_ready) m_streak++;
        else                          m_streak = 0;
        if (m_streak > int'(TO)) m_err = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_MemRead = 1'b0; ex_br_taken = 1'b0;
        mem_access = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic model_reset();
        m_err = 1'b0; m_streak = 0;
        m_stall = 0; m_flush = 0; m_loaduse = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        mem_access = 1'b1; ex_br_taken = 1'b1; ex_MemRead = 1'b1;
        ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
        model_reset();
        #3;
        n_checks++;
        if (obs !== 7'b0) $display("FAIL reset_ctrl: got %b want %b", obs, 7'b0);
        else n_pass++;
        n_checks++;
        if ({mem_timeout_err, stall_cnt, flush_cnt, loaduse_cnt} !== exp_stat())
            $display("FAIL reset_stat: got %h want %h",
                     {mem_timeout_err, stall_cnt, flush_cnt, loaduse_cnt}, exp_stat());
        else n_pass++;
        clear_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_load_use();
        do_reset();
        ex_MemRead = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1; id_rs1 = 5'd9;
        #1;
        n_checks++;
        if (obs !== C_LDUSE) $display("FAIL loaduse_stall: got %b want %b", obs, C_LDUSE);
        else n_pass++;
        tick();
        ex_MemRead = 1'b0;
        #1;
        n_checks++;
        if (obs !== 7'b0) $display("FAIL loaduse_release: got %b want %b", obs, 7'b0);
        else n_pass++;
        n_checks++;
        if (loaduse_cnt !== CW'(1)) $display("FAIL loaduse_cnt: got %0d want 1", loaduse_cnt);
        else n_pass++;
        ex_MemRead = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        #1;
        n_checks++;
        if (obs !== 7'b0) $display("FAIL loaduse_x0: got %b want %b", obs, 7'b0);
        else n_pass++;
        tick();
        clear_inputs();
    endtask

    task automatic test_branch_vs_loaduse();
        do_reset();
        ex_MemRead = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1; ex_br_taken = 1'b1;
        #1;
        n_checks++;
        if (obs !== C_BRANCH) $display("FAIL branch_ctrl: got %b want %b", obs, C_BRANCH);
        else n_pass++;
        tick();
        clear_inputs();
        #1;
        n_checks++;
        if ({flush_cnt, loaduse_cnt, stall_cnt} !== {CW'(1), CW'(0), CW'(0)})
            $display("FAIL branch_cnts: got flush=%0d lu=%0d stall=%0d want 1 0 0",
                     flush_cnt, loaduse_cnt, stall_cnt);
        else n_pass++;
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_access = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (obs !== C_FROZEN) $display("FAIL memwait_freeze%0d: got %b want %b", i, obs, C_FROZEN);
            else n_pass++;
            tick();
        end
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if (obs !== 7'b0) $display("FAIL memwait_ready: got %b want %b", obs, 7'b0);
        else n_pass++;
        tick();
        mem_access = 1'b0; mem_ready = 1'b0;
        #1;
        n_checks++;
        if (stall_cnt !== CW'(3)) $display("FAIL memwait_stallcnt: got %0d want 3", stall_cnt);
        else n_pass++;
        mem_access = 1'b1; mem_ready = 1'b1;
        #1;
        n_checks++;
        if (obs !== 7'b0) $display("FAIL memwait_zerocycle: got %b want %b", obs, 7'b0);
        else n_pass++;
        tick();
        clear_inputs();
    endtask

    task automatic test_branch_under_freeze();
        do_reset();
        ex_br_taken = 1'b1; mem_access = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (obs !== C_FROZEN) $display("FAIL brfreeze_hold%0d: got %b want %b", i, obs, C_FROZEN);
            else n_pass++;
            tick();
        end
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if (obs !== C_BRANCH) $display("FAIL brfreeze_release: got %b want %b", obs, C_BRANCH);
        else n_pass++;
        tick();
        clear_inputs();
        #1;
        n_checks++;
        if (flush_cnt !== CW'(1)) $display("FAIL brfreeze_flushcnt: got %0d want 1", flush_cnt);
        else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        mem_access = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++;
            if (mem_timeout_err !== m_err)
                $display("FAIL timeout_err%0d: got %b want %b", i, mem_timeout_err, m_err);
            else n_pass++;
        end
        mem_ready = 1'b1;
        tick();
        #1;
        n_checks++;
        if ({mem_timeout_err, obs} !== {1'b1, C_FROZEN})
            $display("FAIL timeout_sticky: got %b want %b", {mem_timeout_err, obs}, {1'b1, C_FROZEN});
        else n_pass++;
        n_checks++;
        if ({mem_timeout_err, stall_cnt, flush_cnt, loaduse_cnt} !== exp_stat())
            $display("FAIL timeout_cnts: got %h want %h",
                     {mem_timeout_err, stall_cnt, flush_cnt, loaduse_cnt}, exp_stat());
        else n_pass++;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({mem_timeout_err, stall_cnt, flush_cnt, loaduse_cnt, obs} !== {exp_stat(), 7'b0})
            $display("FAIL timeout_reset: got %h want %h",
                     {mem_timeout_err, stall_cnt, flush_cnt, loaduse_cnt, obs}, {exp_stat(), 7'b0});
        else n_pass++;
        clear_inputs();
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_saturation();
        do_reset();
        ex_MemRead = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; id_use_rs1 = 1'b1;
        for (int i = 0; i < MAXC + 6; i++) tick();
        n_checks++;
        if ({stall_cnt, loaduse_cnt} !== {CW'(MAXC), CW'(MAXC)})
            $display("FAIL sat_cnts: got stall=%0d lu=%0d want %0d", stall_cnt, loaduse_cnt, MAXC);
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_random();
        logic [6:0] e;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            id_use_rs1  = 1'($urandom_range(0, 1));
            id_use_rs2  = 1'($urandom_range(0, 1));
            ex_MemRead  = 1'($urandom_range(0, 1));
            ex_br_taken = ($urandom_range(0, 4) == 0);
            mem_access  = ($urandom_range(0, 2) == 0) || (i % 150 >= 120);
            mem_ready   = (i % 150 >= 120) ? ($urandom_range(0, 9) == 0)
                                           : ($urandom_range(0, 2) != 0);
            #1;
            e = exp_ctrl();
            n_checks++;
            if (obs !== e) $display("FAIL rand_ctrl[%0d]: got %b want %b", i, obs, e);
            else n_pass++;
            n_checks++;
            if ({mem_timeout_err, stall_cnt, flush_cnt, loaduse_cnt} !== exp_stat())
                $display("FAIL rand_stat[%0d]: got %h want %h", i,
                         {mem_timeout_err, stall_cnt, flush_cnt, loaduse_cnt}, exp_stat());
            else n_pass++;
            tick();
            if (m_err && $urandom_range(0, 3) == 0) do_reset();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_vs_loaduse();
        test_mem_wait();
        test_branch_under_freeze();
        test_timeout();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
